qed_consistency_checker: RTL and testbench

//  Far end of the QED duplication path. The instruction modifier turns each original

---
 rtl/qed_consistency_checker_if.sv | 34 +++
 rtl/qed_consistency_checker.sv | 161 ++++++++++++++++
 tb/tb_qed_consistency_checker.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qed_consistency_checker_if.sv
// Commit, ARF read-port and status bundle between the core (master) and the QED consistency checker (slave).
interface qed_consistency_checker_if #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned AW = $clog2(NREG);
  localparam int unsigned IW = $clog2(NREG / 2);

  logic              qed_enable;
  logic [1:0]        commit_valid;
  logic [1:0]        commit_dup;
  logic [AW-1:0]     arf_raddr_a;
  logic [AW-1:0]     arf_raddr_b;
  logic [DATA_W-1:0] arf_rdata_a;
  logic [DATA_W-1:0] arf_rdata_b;
  logic              qed_busy;
  logic              qed_check_done;
  logic              qed_match;
  logic              qed_error;
  logic [IW-1:0]     qed_err_reg;
  logic              qed_cnt_ovf;

  modport master (
    output qed_enable, commit_valid, commit_dup, arf_rdata_a, arf_rdata_b,
    input  arf_raddr_a, arf_raddr_b, qed_busy, qed_check_done, qed_match,
           qed_error, qed_err_reg, qed_cnt_ovf
  );

  modport slave (
    input  qed_enable, commit_valid, commit_dup, arf_rdata_a, arf_rdata_b,
    output arf_raddr_a, arf_raddr_b, qed_busy, qed_check_done, qed_match,
           qed_error, qed_err_reg, qed_cnt_ovf
  );
endinterface

// File: rtl/qed_consistency_checker.sv
// Counts committed originals/duplicates and, once they balance, scans the ARF pairwise
// checking r[i] == r[i+HALF] for i = 1..HALF-1 through two borrowed read ports.
module qed_consistency_checker #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic clk,
  input  logic rst_n,
  qed_consistency_checker_if.slave bus
);
  localparam int unsigned HALF = NREG / 2;
  localparam int unsigned IW   = $clog2(HALF);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [IW-1:0]    IDX_LAST = IW'(HALF - 1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN, S_REPORT} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] orig_cnt_q, orig_cnt_d, dup_cnt_q, dup_cnt_d;
  logic             ovf_q, ovf_d, dirty_q, dirty_d;
  logic [IW-1:0]    idx_q, idx_d, cmp_idx_q, cmp_idx_d, err_reg_q, err_reg_d;
  logic             cmp_pend_q, cmp_pend_d, scan_ok_q, scan_ok_d;
  logic             busy_q, busy_d, done_q, done_d, match_q, match_d;
  logic             error_q, error_d;

  logic       any_commit;
  logic [1:0] n_orig, n_dup;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c, input logic [1:0] n);
    logic [CNT_W:0] s;
    s = {1'b0, c} + (CNT_W + 1)'(n);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  always_comb begin
    any_commit = |bus.commit_valid;
    n_orig = {1'b0, bus.commit_valid[0] & ~bus.commit_dup[0]}
           + {1'b0, bus.commit_valid[1] & ~bus.commit_dup[1]};
    n_dup  = {1'b0, bus.commit_valid[0] & bus.commit_dup[0]}
           + {1'b0, bus.commit_valid[1] & bus.commit_dup[1]};

    state_d    = state_q;
    idx_d      = idx_q;
    cmp_idx_d  = cmp_idx_q;
    cmp_pend_d = cmp_pend_q;
    scan_ok_d  = scan_ok_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    match_d    = 1'b0;
    error_d    = error_q;
    err_reg_d  = err_reg_q;
    orig_cnt_d = sat_add(orig_cnt_q, n_orig);
    dup_cnt_d  = sat_add(dup_cnt_q, n_dup);
    ovf_d      = ovf_q | (orig_cnt_d == CNT_MAX) | (dup_cnt_d == CNT_MAX);
    dirty_d    = dirty_q | any_commit;

    unique case (state_q)
      S_IDLE: begin
        if (dirty_q && (orig_cnt_q == dup_cnt_q) && (orig_cnt_q != '0) && !any_commit && !ovf_q) begin
          state_d    = S_SCAN;
          dirty_d    = 1'b0;
          idx_d      = IW'(1);
          scan_ok_d  = 1'b1;
          busy_d     = 1'b1;
          cmp_pend_d = 1'b0;
        end
      end
      S_SCAN, S_DRAIN: begin
        if (any_commit) begin
          // Abort: the in-flight compare result is dropped, dirty is already set above.
          state_d    = S_IDLE;
          busy_d     = 1'b0;
          cmp_pend_d = 1'b0;
        end else begin
          if (cmp_pend_q && (bus.arf_rdata_a != bus.arf_rdata_b)) begin
            scan_ok_d = 1'b0;
            if (!error_q) begin
              error_d   = 1'b1;
              err_reg_d = cmp_idx_q;
            end
          end
          if (state_q == S_SCAN) begin
            cmp_pend_d = 1'b1;
            cmp_idx_d  = idx_q;
            idx_d      = idx_q + IW'(1);
            if (idx_q == IDX_LAST) state_d = S_DRAIN;
          end else begin
            cmp_pend_d = 1'b0;
            state_d    = S_REPORT;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            match_d    = scan_ok_d;
          end
        end
      end
      S_REPORT: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    if (!bus.qed_enable) begin
      state_d    = S_IDLE;
      idx_d      = '0;
      cmp_idx_d  = '0;
      cmp_pend_d = 1'b0;
      scan_ok_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      match_d    = 1'b0;
      error_d    = 1'b0;
      err_reg_d  = '0;
      orig_cnt_d = '0;
      dup_cnt_d  = '0;
      ovf_d      = 1'b0;
      dirty_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      cmp_idx_q  <= '0;
      cmp_pend_q <= 1'b0;
      scan_ok_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      match_q    <= 1'b0;
      error_q    <= 1'b0;
      err_reg_q  <= '0;
      orig_cnt_q <= '0;
      dup_cnt_q  <= '0;
      ovf_q      <= 1'b0;
      dirty_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      cmp_idx_q  <= cmp_idx_d;
      cmp_pend_q <= cmp_pend_d;
      scan_ok_q  <= scan_ok_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      match_q    <= match_d;
      error_q    <= error_d;
      err_reg_q  <= err_reg_d;
      orig_cnt_q <= orig_cnt_d;
      dup_cnt_q  <= dup_cnt_d;
      ovf_q      <= ovf_d;
      dirty_q    <= dirty_d;
    end
  end

  assign bus.arf_raddr_a    = (state_q == S_SCAN) ? {1'b0, idx_q} : '0;
  assign bus.arf_raddr_b    = (state_q == S_SCAN) ? {1'b1, idx_q} : '0;
  assign bus.qed_busy       = busy_q;
  assign bus.qed_check_done = done_q;
  assign bus.qed_match      = match_q;
  assign bus.qed_error      = error_q;
  assign bus.qed_err_reg    = err_reg_q;
  assign bus.qed_cnt_ovf    = ovf_q;
endmodule

// File: tb/tb_qed_consistency_checker.sv
// Directed + randomized bench for qed_consistency_checker against a pairwise ARF/counter reference model.
module tb_qed_consistency_checker;
  localparam int unsigned NREG = 32;
  localparam int unsigned HALF = NREG / 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qed_consistency_checker_if #(.NREG(NREG), .DATA_W(32)) bus ();
  qed_consistency_checker_if #(.NREG(NREG), .DATA_W(32)) bus4 ();

  qed_consistency_checker #(.NREG(NREG), .DATA_W(32), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));
  qed_consistency_checker #(.NREG(NREG), .DATA_W(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4.slave));

  logic [31:0] arf [NREG];
  always @(posedge clk) begin
    bus.arf_rdata_a <= arf[bus.arf_raddr_a];
    bus.arf_rdata_b <= arf[bus.arf_raddr_b];
  end

  int n_checks = 0;
  int n_fail   = 0;

  // reference model state
  int orig_m = 0, dup_m = 0, o4_m = 0, d4_m = 0;
  bit dirty_m = 0, err_m = 0, ovf4_m = 0;
  int err_reg_m = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    orig_m = 0; dup_m = 0; dirty_m = 0; err_m = 0; err_reg_m = 0;
  endtask

  task automatic commit(input logic [1:0] v, input logic [1:0] d);
    bus.commit_valid = v;
    bus.commit_dup   = d;
    orig_m += $countones(v & ~d);
    dup_m  += $countones(v & d);
    if (v != 2'b00) dirty_m = 1;
    step();
    bus.commit_valid = 2'b00;
    bus.commit_dup   = 2'b00;
  endtask

  task automatic commit4(input logic [1:0] v, input logic [1:0] d);
    bus4.commit_valid = v;
    bus4.commit_dup   = d;
    o4_m = (o4_m + $countones(v & ~d) > 15) ? 15 : o4_m + $countones(v & ~d);
    d4_m = (d4_m + $countones(v & d) > 15) ? 15 : d4_m + $countones(v & d);
    if (o4_m == 15 || d4_m == 15) ovf4_m = 1;
    step();
    bus4.commit_valid = 2'b00;
    bus4.commit_dup   = 2'b00;
    check("ovf4", 64'(bus4.qed_cnt_ovf), 64'(ovf4_m));
  endtask

  task automatic equalize_arf();
    for (int i = 0; i < NREG; i++) arf[i] = $urandom;
    for (int i = 1; i < HALF; i++) arf[i + HALF] = arf[i];
  endtask

  // Current cycle is the trigger cycle T; done must pulse at T+HALF+1.
  task automatic expect_scan();
    bit ok;
    int first;
    ok = 1; first = -1;
    for (int i = 1; i < HALF; i++)
      if (arf[i] !== arf[i + HALF]) begin
        ok = 0;
        if (first < 0) first = i;
      end
    if (!ok && !err_m) begin
      err_m = 1;
      err_reg_m = first;
    end
    for (int k = 1; k <= HALF + 1; k++) begin
      step();
      if (k <= HALF) begin
        check("scan_busy", 64'(bus.qed_busy), 64'(1));
        check("scan_done_early", 64'(bus.qed_check_done), 64'(0));
      end
      if (k < HALF) begin
        check("raddr_a", 64'(bus.arf_raddr_a), 64'(k));
        check("raddr_b", 64'(bus.arf_raddr_b), 64'(k + HALF));
      end
    end
    check("done", 64'(bus.qed_check_done), 64'(1));
    check("match", 64'(bus.qed_match), 64'(ok));
    check("error", 64'(bus.qed_error), 64'(err_m));
    check("err_reg", 64'(bus.qed_err_reg), 64'(err_reg_m));
    check("report_busy", 64'(bus.qed_busy), 64'(0));
    step();
    check("done_one_cycle", 64'(bus.qed_check_done), 64'(0));
    check("raddr_idle", 64'(bus.arf_raddr_a), 64'(0));
    dirty_m = 0;
  endtask

  // Inputs are idle in the current cycle; the model decides whether a scan starts.
  task automatic trigger_scan();
    if (dirty_m && orig_m == dup_m && orig_m != 0) expect_scan();
    else
      for (int k = 0; k < 20; k++) begin
        step();
        check("no_trigger_busy", 64'(bus.qed_busy), 64'(0));
        check("no_trigger_done", 64'(bus.qed_check_done), 64'(0));
      end
  endtask

  initial begin
    logic [1:0] v, d;
    int ro, rd;

    bus.qed_enable = 1'b1; bus.commit_valid = 2'b00; bus.commit_dup = 2'b00;
    bus4.qed_enable = 1'b1; bus4.commit_valid = 2'b00; bus4.commit_dup = 2'b00;
    bus4.arf_rdata_a = '0; bus4.arf_rdata_b = '0;
    for (int i = 0; i < NREG; i++) arf[i] = $urandom;

    // reset with random inputs
    for (int i = 0; i < 4; i++) begin
      bus.commit_valid = 2'($urandom);
      bus.commit_dup   = 2'($urandom);
      bus.qed_enable   = 1'($urandom);
      step();
      check("rst_busy", 64'(bus.qed_busy), 64'(0));
      check("rst_done", 64'(bus.qed_check_done), 64'(0));
      check("rst_match", 64'(bus.qed_match), 64'(0));
      check("rst_error", 64'(bus.qed_error), 64'(0));
      check("rst_err_reg", 64'(bus.qed_err_reg), 64'(0));
      check("rst_ovf", 64'(bus.qed_cnt_ovf), 64'(0));
      check("rst_raddr_a", 64'(bus.arf_raddr_a), 64'(0));
      check("rst_raddr_b", 64'(bus.arf_raddr_b), 64'(0));
    end
    bus.commit_valid = 2'b00; bus.commit_dup = 2'b00; bus.qed_enable = 1'b1;
    rst_n = 1'b1;
    model_clear();
    trigger_scan();

    // 3 originals then 3 duplicates, equal pairs
    equalize_arf();
    for (int i = 0; i < 3; i++) commit(2'b01, 2'b00);
    for (int i = 0; i < 3; i++) commit(2'b01, 2'b01);
    trigger_scan();

    // original + duplicate in one cycle; abort at SCAN cycle 4 with a discarded mismatch on pair 3
    commit(2'b11, 2'b10);
    arf[3 + HALF] = arf[3] ^ 32'h1;
    for (int k = 1; k <= 4; k++) begin
      step();
      check("pre_abort_busy", 64'(bus.qed_busy), 64'(1));
    end
    commit(2'b11, 2'b10);
    check("abort_busy", 64'(bus.qed_busy), 64'(0));
    check("abort_done", 64'(bus.qed_check_done), 64'(0));
    check("abort_error", 64'(bus.qed_error), 64'(err_m));
    check("abort_raddr", 64'(bus.arf_raddr_a), 64'(0));
    arf[3 + HALF] = arf[3];
    trigger_scan();

    // first-mismatch capture, then persistence across a matching scan
    equalize_arf();
    arf[5] = 32'h1234; arf[5 + HALF] = 32'h1235;
    arf[7] = 32'h000A; arf[7 + HALF] = 32'h000B;
    commit(2'b11, 2'b01);
    trigger_scan();
    equalize_arf();
    commit(2'b01, 2'b00);
    commit(2'b10, 2'b10);
    trigger_scan();

    // qed_enable dropped mid-scan
    commit(2'b11, 2'b10);
    for (int k = 1; k <= 8; k++) step();
    bus.qed_enable = 1'b0;
    step();
    bus.qed_enable = 1'b1;
    model_clear();
    check("en_busy", 64'(bus.qed_busy), 64'(0));
    check("en_error", 64'(bus.qed_error), 64'(0));
    check("en_err_reg", 64'(bus.qed_err_reg), 64'(0));
    check("en_raddr_b", 64'(bus.arf_raddr_b), 64'(0));
    trigger_scan();

    // randomized rounds
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < NREG; i++) arf[i] = $urandom;
      for (int i = 1; i < HALF; i++)
        arf[i + HALF] = ($urandom_range(0, 3) == 0) ? arf[i] ^ (32'h1 << $urandom_range(0, 31)) : arf[i];
      ro = $urandom_range(1, 5);
      rd = ro;
      while (ro + rd > 0) begin
        v = 2'b00; d = 2'b00;
        for (int s = 0; s < 2; s++)
          if (ro + rd > 0 && (s == 0 || $urandom_range(0, 1) == 1)) begin
            v[s] = 1'b1;
            if (ro == 0 || (rd > 0 && $urandom_range(0, 1) == 1)) begin d[s] = 1'b1; rd--; end
            else ro--;
          end
        commit(v, d);
      end
      trigger_scan();
    end

    // narrow counters saturate and inhibit the trigger
    for (int i = 0; i < 7; i++) commit4(2'b11, 2'b00);
    commit4(2'b01, 2'b00);
    for (int i = 0; i < 7; i++) commit4(2'b11, 2'b11);
    commit4(2'b01, 2'b01);
    for (int k = 0; k < 20; k++) begin
      step();
      check("ovf_no_scan", 64'(bus4.qed_busy), 64'(0));
    end

    // async reset at SCAN cycle 8 with an error already flagged
    equalize_arf();
    arf[2 + HALF] = ~arf[2];
    commit(2'b11, 2'b10);
    for (int k = 1; k <= 8; k++) step();
    check("pre_rst_error", 64'(bus.qed_error), 64'(1));
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.qed_busy), 64'(0));
    check("arst_error", 64'(bus.qed_error), 64'(0));
    check("arst_err_reg", 64'(bus.qed_err_reg), 64'(0));
    check("arst_raddr", 64'(bus.arf_raddr_a), 64'(0));
    check("arst_ovf4", 64'(bus4.qed_cnt_ovf), 64'(0));
    step();
    rst_n = 1'b1;
    model_clear();
    o4_m = 0; d4_m = 0; ovf4_m = 0;
    trigger_scan();
    commit(2'b01, 2'b01);
    trigger_scan();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
